det_seq_sched: RTL and testbench
================================

// Module: det_seq_sched
// PURPOSE
//  Round-robin scheduler that shares one serial Moore sequence detector (din in, op out, no reset) among N requesters.
//  Grants one requester, captures its W-bit word and shifts it MSB-first onto det_din.
//  Samples det_op once per bit, counts the high samples, and returns the count with a done pulse.
//  Sits between the parallel requesters and the single detector instance.
// PARAMETERS
//  N   4  number of requesters (2..8)
//  W   8  word width, in bits shifted per frame (>=2)
//  CW  4  hit_cnt width; must satisfy 2**CW > W
// PORTS
//  clk      in   1    system clock, rising edge
//  rst      in   1    synchronous reset, active-high
//  req      in   N    level request, one bit per requester; held until gnt
//  data_in  in   N*W  word of requester i in bits [i*W +: W]
//  gnt      out  N    one-hot, one-cycle pulse; the requester's word is captured this cycle
//  busy     out  1    high from the cycle after gnt through the done cycle
//  det_din  out  1    serial bit to the detector
//  det_op   in   1    detector Moore output
//  done     out  1    one-cycle pulse; frame complete
//  done_id  out  3    index of the requester whose frame completed; held until the next done
//  hit_cnt  out  CW   number of det_op=1 samples in the frame (0..W); held until the next done
// BEHAVIOUR
//  Reset: one clk edge with rst=1 forces the following, including mid-frame; the frame in progress is discarded:
//   - FSM=IDLE; gnt=0, busy=0, det_din=0, done=0, done_id=0, hit_cnt=0
//   - RR pointer=N-1, so requester 0 has first priority
//  FSM states: IDLE, PRE (macro only), SHIFT, DRAIN, DONE.
//  IDLE: if |req, select the first set bit searching from ptr+1 upward, wrapping at N.
//   - pulse gnt[sel]; latch data_in slice; ptr<=sel
//   - go to SHIFT, or to PRE when the macro is set
//   - if req==0, stay in IDLE with det_din=0
//  SHIFT: W cycles; cycle k (0..W-1) drives det_din=word[W-1-k].
//  Detector latency is 1 cycle: the op caused by bit k is valid in the next cycle.
//   - det_op is sampled in SHIFT cycles 1..W-1 and in DRAIN, giving exactly W samples
//   - samples taken in PRE or SHIFT cycle 0 are never counted
//  DRAIN: 1 cycle; det_din=0; take the last sample.
//  DONE: 1 cycle; done=1, done_id=sel; hit_cnt<=final count (includes the DRAIN sample).
//   - internal counter clears on entry to SHIFT; next state is IDLE
//  Latency: gnt in cycle T -> done in cycle T+W+2 (T+W+6 with the macro).
//  Throughput: one frame per W+3 cycles (W+7 with the macro).
//  Requests: req is not sampled while busy=1 or in the DONE cycle.
//   - a req rising mid-frame is served at the first IDLE after DONE
//   - a requester that keeps req high after gnt is re-scheduled when its RR turn comes
//  Width: the counter saturates at W; CW bits never overflow.
//  det_din is registered; det_op is used only at the sample point, never combinationally.
// CONFIGURATION
//  SCHED_PREAMBLE_EN defined:
//   - PRE state of 4 cycles drives det_din=0,0,1,1 before the data bits
//   - this synchronising sequence leaves the detector in its output-1 state (S1) from any state, so results are deterministic
//   - PRE samples are not counted
//  Undefined: no PRE state; the detector state carries over from the previous frame.
// TESTING
//  Stub: det_op = det_din delayed one clk (loopback).
//  Real: the team's 4-state Moore detector instance.
//  1 Reset: rst=1 for 2 cycles during SHIFT -> all outputs 0 next cycle, FSM=IDLE;
//     then req=4'b0101 -> gnt=4'b0001 first.
//  2 Stub, req[0], word 8'hF0 -> det_din=1,1,1,1,0,0,0,0 in cycles T+1..T+8;
//     done at T+10, done_id=0, hit_cnt=4.
//  3 Stub, req=4'b1111, each requester drops req after its gnt -> gnt order 0,1,2,3, spaced 11 cycles;
//     then req0 and req2 re-raised -> order 0,2.
//  4 Stub, words 8'h00 and 8'hFF -> hit_cnt=0 and hit_cnt=8 (no wrap); done_id/hit_cnt hold between done pulses.
//  5 Real detector with SCHED_PREAMBLE_EN, word 8'hFF -> det_din=0,0,1,1 then 1 x8;
//     hit_cnt=8, done at T+14.  Word 8'h00 -> hit_cnt=0.
//  6 req[1] rises mid-frame of requester 0 -> gnt[1] not before the IDLE cycle after done; busy low exactly 1 cycle between frames.

Source files
------------

// File: rtl/det_seq_sched.sv
// -----------------------------------------------------------------------------
// det_seq_sched
//
// Round-robin scheduler that lets N requesters share one serial Moore sequence
// detector. The scheduler grants one requester, captures that requester's
// W-bit word, and shifts the word MSB-first onto det_din. It samples det_op
// once per bit, counts how many samples are high, and returns the count
// together with a one-cycle done pulse.
//
// Ports
//   clk      in   1     system clock, rising edge
//   rst      in   1     synchronous reset, active-high
//   req      in   N     level request per requester, held until gnt
//   data_in  in   N*W   word of requester i in bits [i*W +: W]
//   gnt      out  N     one-hot pulse; the granted word is captured this cycle
//   busy     out  1     high from the cycle after gnt through the done cycle
//   det_din  out  1     registered serial bit to the detector
//   det_op   in   1     detector Moore output, sampled once per bit
//   done     out  1     one-cycle pulse, frame complete
//   done_id  out  3     requester whose frame completed, held until next done
//   hit_cnt  out  CW    number of high det_op samples in the frame (0..W)
//
// Optional feature
//   SCHED_PREAMBLE_EN : adds a 4-cycle PRE state that drives 0,0,1,1 ahead of
//   the data bits. That sequence forces the detector into its output-1 state
//   from any starting state, so every frame starts from a known detector state.
//   Without the macro the detector state carries over from the previous frame.
// -----------------------------------------------------------------------------
module det_seq_sched #(
    parameter int N  = 4,   // number of requesters (2..8)
    parameter int W  = 8,   // bits shifted per frame (>= 2)
    parameter int CW = 4    // hit_cnt width, 2**CW > W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic           det_din,
    input  logic           det_op,
    output logic           done,
    output logic [2:0]     done_id,
    output logic [CW-1:0]  hit_cnt
);

    localparam int            KW     = $clog2(W);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(W);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef SCHED_PREAMBLE_EN
        S_PRE,
`endif
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [2:0]      ptr_q;        // last granted requester
    logic [2:0]      id_q;         // requester owning the current frame
    logic [W-1:0]    sh_q;         // remaining bits, next bit in the MSB
    logic [KW-1:0]   bit_q;        // SHIFT cycle index k
    logic [CW-1:0]   cnt_q;        // running count of high samples
    logic            busy_q;
    logic            det_din_q;
    logic            done_q;
    logic [2:0]      done_id_q;
    logic [CW-1:0]   hit_cnt_q;
`ifdef SCHED_PREAMBLE_EN
    logic [1:0]      pre_q;        // PRE cycle index
`endif

    // ------------------------------------------------------------------
    // Round-robin pick: first set request bit after ptr_q, wrapping at N.
    // ------------------------------------------------------------------
    logic         sel_found;
    logic [2:0]   sel_idx;
    logic [W-1:0] sel_word;

    always_comb begin
        int           j;
        logic [N-1:0] req_sh;
        // NOTE: every variable written here gets a default first, otherwise a
        // path that skips the assignment makes synthesis infer a latch.
        sel_found = 1'b0;
        sel_idx   = '0;
        j         = 0;
        req_sh    = '0;
        for (int i = 1; i <= N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) begin
                j = j - N;
            end
            req_sh = req >> j;
            if (!sel_found && req_sh[0]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(j);
            end
        end
        sel_word = W'(data_in >> (int'(sel_idx) * W));
    end

    // The grant has to appear in the same cycle the word is captured, so it is
    // decoded from the registered state and the live request vector.
    always_comb begin
        gnt = '0;
        if (state_q == S_IDLE && !rst && sel_found) begin
            gnt = N'(1) << sel_idx;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this clock edge.
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 3'(N - 1);   // requester 0 gets first priority
            id_q      <= '0;
            sh_q      <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            det_din_q <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            hit_cnt_q <= '0;
`ifdef SCHED_PREAMBLE_EN
            pre_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel_found) begin
                        ptr_q  <= sel_idx;
                        id_q   <= sel_idx;
                        busy_q <= 1'b1;
`ifdef SCHED_PREAMBLE_EN
                        sh_q      <= sel_word;
                        det_din_q <= 1'b0;     // first preamble bit
                        pre_q     <= '0;
                        state_q   <= S_PRE;
`else
                        sh_q      <= sel_word << 1;
                        det_din_q <= sel_word[W-1];
                        bit_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= S_SHIFT;
`endif
                    end else begin
                        det_din_q <= 1'b0;
                    end
                end

`ifdef SCHED_PREAMBLE_EN
                // Preamble 0,0,1,1; det_op is ignored throughout.
                S_PRE: begin
                    pre_q <= pre_q + 1'b1;
                    case (pre_q)
                        2'd0:    det_din_q <= 1'b0;
                        2'd1,
                        2'd2:    det_din_q <= 1'b1;
                        default: begin
                            det_din_q <= sh_q[W-1];
                            sh_q      <= sh_q << 1;
                            bit_q     <= '0;
                            cnt_q     <= '0;
                            state_q   <= S_SHIFT;
                        end
                    endcase
                end
`endif

                S_SHIFT: begin
                    // The detector answers one cycle late, so the sample in
                    // SHIFT cycle 0 belongs to whatever preceded this frame.
                    if (bit_q != '0 && det_op && cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == K_LAST) begin
                        det_din_q <= 1'b0;
                        state_q   <= S_DRAIN;
                    end else begin
                        det_din_q <= sh_q[W-1];
                        sh_q      <= sh_q << 1;
                    end
                end

                // Last sample is the detector's answer to the final data bit;
                // the result is published so it is valid alongside done.
                S_DRAIN: begin
                    if (det_op && cnt_q != CNT_MAX) begin
                        hit_cnt_q <= cnt_q + 1'b1;
                    end else begin
                        hit_cnt_q <= cnt_q;
                    end
                    done_q    <= 1'b1;
                    done_id_q <= id_q;
                    state_q   <= S_DONE;
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign det_din = det_din_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_det_seq_sched.sv
// -----------------------------------------------------------------------------
// tb_det_seq_sched
//
// Directed bench for det_seq_sched. The detector is either a loopback stub
// (det_din delayed one clock) or a small 4-state Moore detector that detects
// two consecutive ones; the preamble 0,0,1,1 drives it into its output-1 state.
// Outputs are sampled on the falling edge, inputs change 1 time unit after the
// rising edge. The bench adapts its timing to SCHED_PREAMBLE_EN.
// -----------------------------------------------------------------------------
module tb_det_seq_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 4;
`ifdef SCHED_PREAMBLE_EN
    localparam int PRE_LEN = 4;
`else
    localparam int PRE_LEN = 0;
`endif
    localparam int LAT = W + 2 + PRE_LEN;   // gnt cycle -> done cycle
    localparam int FR  = W + 3 + PRE_LEN;   // gnt to gnt when back-to-back
    localparam int TR  = 4096;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in = '0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           det_din;
    logic           det_op;
    logic           done;
    logic [2:0]     done_id;
    logic [CW-1:0]  hit_cnt;

    det_seq_sched #(.N(N), .W(W), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .busy    (busy),
        .det_din (det_din),
        .det_op  (det_op),
        .done    (done),
        .done_id (done_id),
        .hit_cnt (hit_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Detector models.
    logic       stub_q = 1'b0;
    logic [1:0] det_st = 2'd2;   // 0:idle 1:two ones (out 1) 2:one 1 3:after 1-run
    logic       use_real = 1'b0;
    always @(posedge clk) stub_q <= det_din;
    always @(posedge clk) begin
        if (det_din) det_st <= (det_st == 2'd0 || det_st == 2'd3) ? 2'd2 : 2'd1;
        else         det_st <= (det_st == 2'd1) ? 2'd3 : 2'd0;
    end
    assign det_op = use_real ? (det_st == 2'd1) : stub_q;

    // Per-cycle traces and event logs.
    logic          din_tr  [0:TR-1];
    logic          busy_tr [0:TR-1];
    logic          done_tr [0:TR-1];
    logic [2:0]    id_tr   [0:TR-1];
    logic [CW-1:0] hit_tr  [0:TR-1];
    logic [N-1:0]  g_vec [$];
    int            g_cyc [$];
    int            d_id  [$];
    int            d_hit [$];
    int            d_cyc [$];
    logic          auto_drop = 1'b1;
    logic [N-1:0]  last_g;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles: sample at the falling edge, then step past the rising
    // edge. A granted requester drops its request right after the grant.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cyc < TR) begin
                din_tr[cyc]  = det_din;
                busy_tr[cyc] = busy;
                done_tr[cyc] = done;
                id_tr[cyc]   = done_id;
                hit_tr[cyc]  = hit_cnt;
            end
            if (gnt != '0) begin
                g_vec.push_back(gnt);
                g_cyc.push_back(cyc);
            end
            if (done) begin
                d_id.push_back(int'(done_id));
                d_hit.push_back(int'(hit_cnt));
                d_cyc.push_back(cyc);
            end
            last_g = gnt;
            @(posedge clk);
            #1;
            if (auto_drop) req = req & ~last_g;
        end
    endtask

    task automatic wait_done(input string tag, input int k, input int budget);
        int base;
        int used;
        base = d_cyc.size();
        used = 0;
        while (d_cyc.size() < base + k && used < budget) begin
            run(1);
            used++;
        end
        check(tag, 32'(d_cyc.size() - base), 32'(k));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_gnt"},  32'(gnt), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_din"},  32'(det_din), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_id"},   32'(done_id), 0);
        check({tag, "_hit"},  32'(hit_cnt), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] word8(input logic [7:0] v);
        return W'(v);
    endfunction

    initial begin
        int           gb;
        int           db;
        int           t;
        logic [W-1:0] wd;
        logic [3:0]   pat;

        pat = 4'b0011;
        @(posedge clk);
        #1;
        do_reset(2);
        check_zero("rst_init");

        // Frame from requester 2, word FF: gives non-zero done_id/hit_cnt.
        data_in[2*W +: W] = word8(8'hFF);
        req = 4'b0100;
        db = d_cyc.size();
        wait_done("a_ndone", 1, 40);
        check("a_id", 32'(d_id[db]), 2);
        check("a_hit", 32'(d_hit[db]), 8);

        // Reset for two cycles in the middle of a frame; the frame is dropped.
        data_in[1*W +: W] = word8(8'hA5);
        req = 4'b0010;
        run(3 + PRE_LEN);
        check("t1_busy_pre_rst", 32'(busy), 1);
        do_reset(2);
        check_zero("t1_rst_mid");
        db = d_cyc.size();
        run(20);
        check("t1_discard", 32'(d_cyc.size() - db), 0);
        // Pointer back at N-1: requester 0 before requester 2.
        gb = g_vec.size();
        req = 4'b0101;
        wait_done("t1_ndone", 2, 60);
        check("t1_gnt0", 32'(g_vec[gb]), 32'h1);
        check("t1_gnt1", 32'(g_vec[gb + 1]), 32'h4);

        // Requester 0, word F0 through the loopback stub.
        do_reset(1);
        wd = word8(8'hF0);
        data_in[0 +: W] = wd;
        req = 4'b0001;
        gb = g_vec.size();
        db = d_cyc.size();
        wait_done("t2_ndone", 1, 40);
        t = g_cyc[gb];
        check("t2_gnt", 32'(g_vec[gb]), 32'h1);
        for (int p = 0; p < PRE_LEN; p++) begin
            check($sformatf("t2_pre%0d", p), 32'(din_tr[t + 1 + p]), 32'(pat[3 - p]));
        end
        for (int k = 0; k < W; k++) begin
            check($sformatf("t2_din%0d", k), 32'(din_tr[t + 1 + PRE_LEN + k]), 32'(wd[W - 1 - k]));
        end
        check("t2_lat", 32'(d_cyc[db] - t), 32'(LAT));
        check("t2_id", 32'(d_id[db]), 0);
        check("t2_hit", 32'(d_hit[db]), 4);
        check("t2_done_pulse", 32'(done_tr[d_cyc[db] + 1]), 0);

        // All four request together; each drops after its grant.
        do_reset(1);
        data_in = {word8(8'h81), word8(8'h18), word8(8'h3C), word8(8'hC3)};
        req = 4'b1111;
        gb = g_vec.size();
        wait_done("t3_ndone", 4, 80);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_gnt%0d", i), 32'(g_vec[gb + i]), 32'(1 << i));
        end
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t3_gap%0d", i), 32'(g_cyc[gb + i] - g_cyc[gb + i - 1]), 32'(FR));
        end
        gb = g_vec.size();
        req = 4'b0101;
        wait_done("t3b_ndone", 2, 60);
        check("t3b_gnt0", 32'(g_vec[gb]), 32'h1);
        check("t3b_gnt1", 32'(g_vec[gb + 1]), 32'h4);

        // Words 00 and FF: count bounds and hold between done pulses.
        data_in[1*W +: W] = word8(8'h00);
        data_in[3*W +: W] = word8(8'hFF);
        req = 4'b1010;
        db = d_cyc.size();
        wait_done("t4_ndone", 2, 60);
        check("t4_id0", 32'(d_id[db]), 3);
        check("t4_hit0", 32'(d_hit[db]), 8);
        check("t4_id1", 32'(d_id[db + 1]), 1);
        check("t4_hit1", 32'(d_hit[db + 1]), 0);
        check("t4_hold_id_a", 32'(id_tr[d_cyc[db] + 1]), 3);
        check("t4_hold_hit_a", 32'(hit_tr[d_cyc[db] + 1]), 8);
        check("t4_hold_id_b", 32'(id_tr[d_cyc[db + 1] - 1]), 3);
        check("t4_hold_hit_b", 32'(hit_tr[d_cyc[db + 1] - 1]), 8);

        // Requester 1 raises its request while requester 0 is mid-frame.
        data_in[0 +: W] = word8(8'h3C);
        data_in[1*W +: W] = word8(8'h96);
        req = 4'b0001;
        gb = g_vec.size();
        for (int i = 0; i < 10 && g_vec.size() == gb; i++) run(1);
        check("t6_gnt0_seen", 32'(g_vec.size() - gb), 1);
        t = g_cyc[gb];
        run(2);
        req = req | 4'b0010;
        wait_done("t6_ndone", 2, 60);
        check("t6_gnt0", 32'(g_vec[gb]), 32'h1);
        check("t6_gnt1", 32'(g_vec[gb + 1]), 32'h2);
        check("t6_gap", 32'(g_cyc[gb + 1] - t), 32'(FR));
        check("t6_busy_t", 32'(busy_tr[t]), 0);
        check("t6_busy_t1", 32'(busy_tr[t + 1]), 1);
        check("t6_busy_done", 32'(busy_tr[t + FR - 1]), 1);
        check("t6_busy_gap", 32'(busy_tr[t + FR]), 0);
        check("t6_busy_next", 32'(busy_tr[t + FR + 1]), 1);

`ifdef SCHED_PREAMBLE_EN
        // Real detector behind the preamble.
        use_real = 1'b1;
        data_in[0 +: W] = word8(8'hFF);
        req = 4'b0001;
        gb = g_vec.size();
        db = d_cyc.size();
        wait_done("t5_ndone", 1, 40);
        t = g_cyc[gb];
        for (int p = 0; p < 4; p++) begin
            check($sformatf("t5_pre%0d", p), 32'(din_tr[t + 1 + p]), 32'(pat[3 - p]));
        end
        for (int k = 0; k < W; k++) begin
            check($sformatf("t5_din%0d", k), 32'(din_tr[t + 5 + k]), 1);
        end
        check("t5_lat", 32'(d_cyc[db] - t), 14);
        check("t5_hit_ff", 32'(d_hit[db]), 8);
        data_in[0 +: W] = word8(8'h00);
        req = 4'b0001;
        db = d_cyc.size();
        wait_done("t5b_ndone", 1, 40);
        check("t5_hit_00", 32'(d_hit[db]), 0);
        use_real = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
